// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: burst encodings, response codes, responder FSM states.
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // WRAP is only legal for 2, 4, 8 or 16 beats; other lengths fall back to INCR.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address generator (FIXED / INCR / WRAP).
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr_c
);

    localparam int unsigned BPB      = DATA_WIDTH / 8;
    localparam int unsigned BPB_LOG2 = $clog2(BPB);

    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // Every beat is full width, so the step is always BPB bytes.
    always_comb begin
        incr_addr   = addr + ADDR_WIDTH'(BPB);
        wrap_mask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << BPB_LOG2) - ADDR_WIDTH'(1);
        next_addr_c = incr_addr;
        case (burst)
            BURST_FIXED: next_addr_c = addr;
            BURST_WRAP: begin
                if (wrap_len_ok(len)) begin
                    next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                end
            end
            default: next_addr_c = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 memory-backed responder: one write and one read burst in flight.
// Optional macro AXI4_SLAVE_ERR_RESP_EN enables SLVERR on out-of-range start
// addresses and on wlast mismatch; otherwise addresses wrap modulo MEM_DEPTH.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic [1:0]            rresp
);

    localparam int unsigned BPB      = DATA_WIDTH / 8;
    localparam int unsigned BPB_LOG2 = $clog2(BPB);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);

`ifdef AXI4_SLAVE_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[BPB_LOG2 +: IDX_W];
    endfunction

    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
        return ERR_EN && ((a >> (BPB_LOG2 + IDX_W)) != '0);
    endfunction

    // Beat size is fixed at full width; size fields are accepted but not used.
    logic unused_size;
    assign unused_size = ^{awsize, arsize};

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ---------------- write channel state ----------------
    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic                  w_oor_q, w_oor_d;
    logic                  w_wlast_err_q, w_wlast_err_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] w_next_addr_c;
    logic                  mem_we_c;
    logic [IDX_W-1:0]      mem_widx_c;
    logic                  w_last_beat_c;
    logic                  w_wlast_bad_c;

    // ---------------- read channel state ----------------
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic                  r_oor_q, r_oor_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] r_next_addr_c;

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_w_addr_gen (
        .addr        (w_addr_q),
        .len         (w_len_q),
        .burst       (w_burst_q),
        .next_addr_c (w_next_addr_c)
    );

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_r_addr_gen (
        .addr        (r_addr_q),
        .len         (r_len_q),
        .burst       (r_burst_q),
        .next_addr_c (r_next_addr_c)
    );

    // Write FSM next-state: address latch, beat counting, response generation.
    always_comb begin
        w_state_d     = w_state_q;
        w_addr_d      = w_addr_q;
        w_len_d       = w_len_q;
        w_burst_d     = w_burst_q;
        w_cnt_d       = w_cnt_q;
        w_oor_d       = w_oor_q;
        w_wlast_err_d = w_wlast_err_q;
        awready_d     = awready_q;
        wready_d      = wready_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        mem_we_c      = 1'b0;
        mem_widx_c    = word_idx(w_addr_q);
        w_last_beat_c = (w_cnt_q == w_len_q);
        w_wlast_bad_c = ERR_EN && (wlast != w_last_beat_c);

        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    w_addr_d      = awaddr;
                    w_len_d       = awlen;
                    w_burst_d     = awburst;
                    w_cnt_d       = 8'd0;
                    w_oor_d       = addr_oor(awaddr);
                    w_wlast_err_d = 1'b0;
                    awready_d     = 1'b0;
                    wready_d      = 1'b1;
                    w_state_d     = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // Out-of-range bursts still consume all beats but never store.
                    mem_we_c = !w_oor_q;
                    w_addr_d = w_next_addr_c;
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_wlast_bad_c) begin
                        w_wlast_err_d = 1'b1;
                    end
                    if (w_last_beat_c) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_oor_q || w_wlast_err_q || w_wlast_bad_c) ?
                                    RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Read FSM next-state: rdata is prefetched into a register one beat ahead.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_oor_d   = r_oor_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_burst_d = arburst;
                    r_cnt_d   = 8'd0;
                    r_oor_d   = addr_oor(araddr);
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = addr_oor(araddr) ? '0 : mem_q[word_idx(araddr)];
                    rlast_d   = (arlen == 8'd0);
                    rresp_d   = addr_oor(araddr) ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_next_addr_c;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rdata_d  = r_oor_q ? '0 : mem_q[word_idx(r_next_addr_c)];
                        rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Channel state registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q     <= W_IDLE;
            w_addr_q      <= '0;
            w_len_q       <= 8'd0;
            w_burst_q     <= 2'b00;
            w_cnt_q       <= 8'd0;
            w_oor_q       <= 1'b0;
            w_wlast_err_q <= 1'b0;
            awready_q     <= 1'b1;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            r_state_q     <= R_IDLE;
            r_addr_q      <= '0;
            r_len_q       <= 8'd0;
            r_burst_q     <= 2'b00;
            r_cnt_q       <= 8'd0;
            r_oor_q       <= 1'b0;
            arready_q     <= 1'b1;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rlast_q       <= 1'b0;
            rresp_q       <= RESP_OKAY;
        end else begin
            w_state_q     <= w_state_d;
            w_addr_q      <= w_addr_d;
            w_len_q       <= w_len_d;
            w_burst_q     <= w_burst_d;
            w_cnt_q       <= w_cnt_d;
            w_oor_q       <= w_oor_d;
            w_wlast_err_q <= w_wlast_err_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            r_state_q     <= r_state_d;
            r_addr_q      <= r_addr_d;
            r_len_q       <= r_len_d;
            r_burst_q     <= r_burst_d;
            r_cnt_q       <= r_cnt_d;
            r_oor_q       <= r_oor_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rlast_q       <= rlast_d;
            rresp_q       <= rresp_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_widx_c] <= wdata;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem; honours AXI4_SLAVE_ERR_RESP_EN if defined.
module tb_axi4_slave_mem;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 64;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned BPB     = 8;
    localparam int          TIMEOUT = 50;

`ifdef AXI4_SLAVE_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic          arvalid, arready, rvalid, rready, rlast;

    always #5 clk = ~clk;

    axi4_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp)
    );

    logic [DW-1:0] model_mem [DEPTH];
    logic [1:0]    exp_bresp_q [$];
    logic [DW-1:0] exp_rdata_q [$];
    logic          exp_rlast_q [$];
    logic [1:0]    exp_rresp_q [$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic [7:0] len,
                                          input logic [1:0] b);
        int unsigned bnd;
        if (b == 2'b00) return a;
        if (b == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            bnd = (int'(len) + 1) * BPB;
            return (a & ~(bnd - 1)) | ((a + BPB) & (bnd - 1));
        end
        return a + BPB;
    endfunction

    function automatic logic [9:0] idx(input logic [AW-1:0] a);
        return a[12:3];
    endfunction

    function automatic bit oor(input logic [AW-1:0] a);
        return ERR_EN && ((a >> 13) != 0);
    endfunction

    task automatic do_aw(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] b);
        int n = 0;
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = addr; awlen = len; awburst = b; awsize = 3'd3;
        @(negedge clk);
        while (!awready && n < TIMEOUT) begin @(negedge clk); n++; end
        checks++;
        if (awready !== 1'b1) begin failures++; $display("FAIL aw_handshake: awready=%0b required=1", awready); end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] b);
        int n = 0;
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = addr; arlen = len; arburst = b; arsize = 3'd3;
        @(negedge clk);
        while (!arready && n < TIMEOUT) begin @(negedge clk); n++; end
        checks++;
        if (arready !== 1'b1) begin failures++; $display("FAIL ar_handshake: arready=%0b required=1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    // Full write burst; wlast_beat is the beat index that carries wlast (-1 for none).
    task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] b,
                             input logic [DW-1:0] base, input int wlast_beat);
        logic [AW-1:0] a = addr;
        bit discard = oor(addr);
        bit bad = ERR_EN && (wlast_beat != int'(len));
        int n;
        do_aw(addr, len, b);
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = base + DW'(i); wlast = (i == wlast_beat);
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (wready !== 1'b1 || awready !== 1'b0) begin
                    failures++;
                    $display("FAIL aw_to_w: wready=%0b awready=%0b required 1/0", wready, awready);
                end
            end
            n = 0;
            while (!wready && n < TIMEOUT) begin @(negedge clk); n++; end
            checks++;
            if (wready !== 1'b1) begin failures++; $display("FAIL w_beat%0d: wready=%0b required=1", i, wready); end
            if (!discard) model_mem[idx(a)] = base + DW'(i);
            a = nxt(a, len, b);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_bresp_q.push_back((discard || bad) ? 2'b10 : 2'b00);
    endtask

    // Must be called right after axi_write: first sample is the cycle after the last W beat.
    task automatic take_bresp(input int hold);
        logic [1:0] held, exp;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1) begin failures++; $display("FAIL b_latency: bvalid=%0b required=1", bvalid); end
        held = bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || bresp !== held || awready !== 1'b0) begin
                failures++;
                $display("FAIL b_hold: bvalid=%0b bresp=%0b awready=%0b required 1/%0b/0", bvalid, bresp, awready, held);
            end
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        exp = (exp_bresp_q.size() != 0) ? exp_bresp_q.pop_front() : 2'bxx;
        checks++;
        if (bvalid !== 1'b1 || bresp !== exp) begin
            failures++;
            $display("FAIL bresp: bvalid=%0b bresp=%0b required 1/%0b", bvalid, bresp, exp);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            failures++;
            $display("FAIL b_done: bvalid=%0b awready=%0b required 0/1", bvalid, awready);
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] b,
                            input bit toggle);
        logic [AW-1:0] a = addr;
        bit err = oor(addr);
        bit done = 0, stalled = 0;
        int cyc = 0;
        logic [DW-1:0] p_data, e_data;
        logic p_last, e_last;
        logic [1:0] p_resp, e_resp;
        for (int i = 0; i <= int'(len); i++) begin
            exp_rdata_q.push_back(err ? '0 : model_mem[idx(a)]);
            exp_rlast_q.push_back(i == int'(len));
            exp_rresp_q.push_back(err ? 2'b10 : 2'b00);
            a = nxt(a, len, b);
        end
        do_ar(addr, len, b);
        rready = toggle ? 1'b0 : 1'b1;
        while (!done && cyc < TIMEOUT * 4) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (rvalid !== 1'b1) begin failures++; $display("FAIL r_latency: rvalid=%0b required=1", rvalid); end
            end
            if (stalled) begin
                checks++;
                if (rvalid !== 1'b1 || rdata !== p_data || rlast !== p_last || rresp !== p_resp) begin
                    failures++;
                    $display("FAIL r_stall: rvalid=%0b rdata=%h rlast=%0b required 1/%h/%0b", rvalid, rdata, rlast, p_data, p_last);
                end
            end
            stalled = 0;
            if (rvalid && rready) begin
                if (exp_rdata_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL r_extra_beat: rdata=%h required no beat", rdata);
                    done = 1;
                end else begin
                    e_data = exp_rdata_q.pop_front();
                    e_last = exp_rlast_q.pop_front();
                    e_resp = exp_rresp_q.pop_front();
                    checks++;
                    if (rdata !== e_data || rlast !== e_last || rresp !== e_resp) begin
                        failures++;
                        $display("FAIL r_beat: rdata=%h rlast=%0b rresp=%0b required %h/%0b/%0b", rdata, rlast, rresp, e_data, e_last, e_resp);
                    end
                    if (rlast) done = 1;
                end
            end else if (rvalid) begin
                stalled = 1; p_data = rdata; p_last = rlast; p_resp = rresp;
            end
            @(posedge clk); #1;
            cyc++;
            rready = toggle ? (cyc % 2 == 1) : 1'b1;
        end
        rready = 1'b0;
        checks++;
        if (!done || exp_rdata_q.size() != 0) begin
            failures++;
            $display("FAIL r_burst_end: done=%0b beats_left=%0d required 1/0", done, exp_rdata_q.size());
        end
        exp_rdata_q.delete(); exp_rlast_q.delete(); exp_rresp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; awaddr = '0; awlen = 0; awsize = 3'd3; awburst = 2'b01;
        wvalid = 0; wdata = '0; wlast = 0; bready = 0;
        arvalid = 0; araddr = '0; arlen = 0; arsize = 3'd3; arburst = 2'b01; rready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_ctrl: aw/ar/w/b/rv/rl=%b required 110000", {awready, arready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== '0) begin
            failures++;
            $display("FAIL reset_data: bresp=%0b rresp=%0b rdata=%h required 0/0/0", bresp, rresp, rdata);
        end
    endtask

    task automatic test_incr();
        axi_write(32'h100, 8'd3, 2'b01, 64'd1, 3);
        take_bresp(0);
        axi_read(32'h100, 8'd3, 2'b01, 1'b0);
    endtask

    task automatic test_wrap();
        axi_write(32'h100, 8'd3, 2'b01, 64'h10, 3);
        take_bresp(0);
        // Beats hit 0x118, 0x100, 0x108, 0x110 -> 0x13, 0x10, 0x11, 0x12.
        axi_read(32'h118, 8'd3, 2'b10, 1'b0);
        axi_read(32'h100, 8'd0, 2'b00, 1'b0);
    endtask

    task automatic test_back_to_back_stall();
        axi_write(32'h200, 8'd7, 2'b01, 64'hA000, 7);
        take_bresp(5);
        axi_read(32'h200, 8'd7, 2'b01, 1'b1);
        axi_read(32'h208, 8'd2, 2'b00, 1'b1);
    endtask

    task automatic test_out_of_range();
        axi_write(32'h10, 8'd0, 2'b01, 64'hAA, 0);
        take_bresp(0);
        axi_write(32'h2010, 8'd0, 2'b01, 64'hBB, 0);
        take_bresp(0);
        axi_read(32'h10, 8'd0, 2'b01, 1'b0);
        axi_read(32'h2010, 8'd1, 2'b01, 1'b0);
    endtask

    task automatic test_wlast();
        axi_write(32'h400, 8'd3, 2'b01, 64'h40, 1);
        take_bresp(0);
        axi_read(32'h400, 8'd3, 2'b01, 1'b0);
        axi_write(32'h480, 8'd1, 2'b01, 64'h50, -1);
        take_bresp(0);
    endtask

    task automatic test_reset_mid_burst();
        do_aw(32'h300, 8'd3, 2'b01);
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = 64'hDEAD + DW'(i); wlast = 1'b0;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: awready=%0b wready=%0b bvalid=%0b required 1/0/0", awready, wready, bvalid);
        end
        axi_write(32'h300, 8'd3, 2'b01, 64'h500, 3);
        take_bresp(0);
        axi_read(32'h300, 8'd3, 2'b01, 1'b0);
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_back_to_back_stall();
        test_out_of_range();
        test_wlast();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
